// File: rtl/ultrasonic_scheduler.sv
// Round-robin scheduler for HC-SR04-style rangers sharing one trigger/echo timing engine.
// Fires one enabled channel at a time, times its echo in us and reports the distance in cm.
module ultrasonic_scheduler #(
  parameter int unsigned NUM_SENS   = 4,
  parameter int unsigned CLK_PER_US = 100,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned TIMEOUT_US = 23200,
  parameter int unsigned GAP_US     = 60000,
  parameter int unsigned CM_DIV     = 58
) (
  input  logic                        clk,
  input  logic                        reset_p,
  input  logic                        enable,
  input  logic [NUM_SENS-1:0]         sensor_mask,
  input  logic [NUM_SENS-1:0]         echo,
  output logic [NUM_SENS-1:0]         trigger,
  output logic [$clog2(NUM_SENS)-1:0] sel,
  output logic                        busy,
  output logic [8:0]                  dist_cm,
  output logic                        dist_valid,
  output logic                        timeout
);

  localparam int unsigned SW      = $clog2(NUM_SENS);
  localparam int unsigned PW      = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int unsigned CNT_MAX = (TIMEOUT_US > GAP_US) ? TIMEOUT_US : GAP_US;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIG,
    S_WAIT_RISE,
    S_MEASURE,
    S_GAP
  } state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] sel_q, sel_d, next_sel;
  logic          first_q, first_d, found;
  logic [PW-1:0] pres_q, pres_d;
  logic [CW-1:0] us_q, us_d, us_inc;
  logic          tick;
  logic [1:0]    sync_q, sync_d;
  logic          prev_q, prev_d, rise, fall;
  logic [8:0]    dist_cm_q, dist_cm_d;
  logic          dist_valid_q, dist_valid_d;
  logic          timeout_q, timeout_d;
  logic [31:0]   quot;

  assign tick   = (pres_q == PW'(CLK_PER_US - 1));
  assign us_inc = (tick && (us_q != CW'(CNT_MAX))) ? us_q + CW'(1) : us_q;
  assign rise   = sync_q[1] & ~prev_q;
  assign fall   = ~sync_q[1] & prev_q;
  // us_inc includes the tick of the fall cycle, so the quotient covers every echo-high clock
  assign quot   = 32'(us_inc) / CM_DIV;

  // Circular search starting just after the last serviced channel; lowest bit first after reset
  always_comb begin
    logic [SW-1:0] cand;
    next_sel = sel_q;
    found    = 1'b0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_SENS; i++) begin
      cand = first_q ? SW'(i) : SW'((32'(sel_q) + 32'd1 + i) % NUM_SENS);
      if (!found && sensor_mask[cand]) begin
        found    = 1'b1;
        next_sel = cand;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    first_d      = first_q;
    dist_cm_d    = dist_cm_q;
    dist_valid_d = 1'b0;
    timeout_d    = 1'b0;
    sync_d       = {sync_q[0], echo[sel_q]};
    prev_d       = sync_q[1];
    pres_d       = '0;
    us_d         = '0;

    case (state_q)
      S_IDLE: begin
        if (enable && found) begin
          sel_d   = next_sel;
          first_d = 1'b0;
          state_d = S_TRIG;
        end
      end
      S_TRIG: begin
        if (tick && (us_q == CW'(TRIG_US - 1))) state_d = S_WAIT_RISE;
      end
      S_WAIT_RISE: begin
        if (rise) begin
          state_d = S_MEASURE;
        end else if (us_q >= CW'(TIMEOUT_US)) begin
          timeout_d = 1'b1;
          state_d   = S_GAP;
        end
      end
      S_MEASURE: begin
        if (fall) begin
          dist_cm_d    = (quot > 32'd511) ? 9'd511 : quot[8:0];
          dist_valid_d = 1'b1;
          state_d      = S_GAP;
        end else if (us_q >= CW'(TIMEOUT_US)) begin
          timeout_d = 1'b1;
          state_d   = S_GAP;
        end
      end
      S_GAP: begin
        if (tick && (us_q == CW'(GAP_US - 1))) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything: results of the killed shot are dropped
    if (!enable) begin
      state_d      = S_IDLE;
      dist_cm_d    = dist_cm_q;
      dist_valid_d = 1'b0;
      timeout_d    = 1'b0;
    end

    if (state_d == state_q) begin
      pres_d = tick ? '0 : pres_q + PW'(1);
      us_d   = us_inc;
    end
  end

  always_ff @(posedge clk or posedge reset_p) begin
    if (reset_p) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      first_q      <= 1'b1;
      pres_q       <= '0;
      us_q         <= '0;
      sync_q       <= '0;
      prev_q       <= 1'b0;
      dist_cm_q    <= '0;
      dist_valid_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      first_q      <= first_d;
      pres_q       <= pres_d;
      us_q         <= us_d;
      sync_q       <= sync_d;
      prev_q       <= prev_d;
      dist_cm_q    <= dist_cm_d;
      dist_valid_q <= dist_valid_d;
      timeout_q    <= timeout_d;
    end
  end

  always_comb begin
    trigger = '0;
    if (state_q == S_TRIG) trigger[sel_q] = 1'b1;
  end

  assign sel        = sel_q;
  assign busy       = (state_q != S_IDLE);
  assign dist_cm    = dist_cm_q;
  assign dist_valid = dist_valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_ultrasonic_scheduler.sv
// Directed bench for ultrasonic_scheduler: a scaled-down 4-channel instance plus two
// 1 us/clk instances for long echoes and the 511 cm saturation.
`timescale 1ns/1ps
module tb_ultrasonic_scheduler;

  localparam int unsigned P = 2;

  logic       clk = 1'b0;
  logic       reset_p, enable;
  logic [3:0] sensor_mask, echo, echo_resp, echo_force, trigger;
  logic [1:0] sel;
  logic       busy, dist_valid, timeout;
  logic [8:0] dist_cm;

  logic       big_en;
  logic [1:0] big_mask, big_echo, big_trig, clamp_trig;
  logic [0:0] big_sel, clamp_sel;
  logic       big_busy, big_dv, big_to, clamp_busy, clamp_dv, clamp_to;
  logic [8:0] big_dist, clamp_dist;

  int unsigned n_checks = 0, n_fail = 0;
  int unsigned n_valid = 0, n_to = 0, n_both = 0, n_busy = 0, n_multi = 0, tw = 0;
  int unsigned pch_q[$], pw_q[$];
  int unsigned echo_len[4];
  bit          resp_busy = 1'b0;

  assign echo = echo_resp | echo_force;

  always #5 clk = ~clk;

  ultrasonic_scheduler #(.NUM_SENS(4), .CLK_PER_US(P), .TRIG_US(10), .TIMEOUT_US(1000),
                         .GAP_US(20), .CM_DIV(58)) u_dut (
    .clk(clk), .reset_p(reset_p), .enable(enable), .sensor_mask(sensor_mask), .echo(echo),
    .trigger(trigger), .sel(sel), .busy(busy), .dist_cm(dist_cm), .dist_valid(dist_valid),
    .timeout(timeout));

  ultrasonic_scheduler #(.NUM_SENS(2), .CLK_PER_US(1), .TRIG_US(10), .TIMEOUT_US(40000),
                         .GAP_US(20), .CM_DIV(58)) u_big (
    .clk(clk), .reset_p(reset_p), .enable(big_en), .sensor_mask(big_mask), .echo(big_echo),
    .trigger(big_trig), .sel(big_sel), .busy(big_busy), .dist_cm(big_dist), .dist_valid(big_dv),
    .timeout(big_to));

  ultrasonic_scheduler #(.NUM_SENS(2), .CLK_PER_US(1), .TRIG_US(10), .TIMEOUT_US(40000),
                         .GAP_US(20), .CM_DIV(50)) u_clamp (
    .clk(clk), .reset_p(reset_p), .enable(big_en), .sensor_mask(big_mask), .echo(big_echo),
    .trigger(clamp_trig), .sel(clamp_sel), .busy(clamp_busy), .dist_cm(clamp_dist),
    .dist_valid(clamp_dv), .timeout(clamp_to));

  function automatic int unsigned oh_idx(input logic [3:0] v);
    int unsigned r = 99;
    for (int unsigned i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Pulse monitor and trigger-pulse log (channel, width in clocks)
  always @(negedge clk) begin
    if (dist_valid) n_valid++;
    if (timeout) n_to++;
    if (dist_valid && timeout) n_both++;
    if (busy) n_busy++;
    if (!$onehot0(trigger)) n_multi++;
    if (trigger != 4'd0) begin
      if (tw == 0) pch_q.push_back(oh_idx(trigger));
      tw++;
    end else if (tw != 0) begin
      pw_q.push_back(tw);
      tw = 0;
    end
  end

  // Sensor model: echo of echo_len[ch] us starting 5 us after that channel's trigger falls
  initial begin
    logic [3:0]  tp;
    int unsigned ch;
    tp = '0;
    echo_resp = '0;
    forever begin
      @(negedge clk);
      if (tp != 4'd0 && trigger == 4'd0) begin
        ch = oh_idx(tp);
        if (ch < 4 && echo_len[ch] != 0) begin
          resp_busy = 1'b1;
          repeat (5 * P) @(negedge clk);
          echo_resp[ch] = 1'b1;
          repeat (echo_len[ch] * P) @(negedge clk);
          echo_resp[ch] = 1'b0;
          resp_busy = 1'b0;
        end
      end
      tp = trigger;
    end
  end

  task automatic wait_result(input int unsigned budget, output bit v, output bit t);
    v = 1'b0;
    t = 1'b0;
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dist_valid || timeout) begin
        v = dist_valid;
        t = timeout;
        break;
      end
    end
  endtask

  task automatic expect_dist(input string tag, input int unsigned es, input int unsigned ed);
    bit v, t;
    wait_result(4000, v, t);
    check({tag, "_valid"}, 32'(v), 1);
    check({tag, "_sel"}, 32'(sel), es);
    check({tag, "_dist"}, 32'(dist_cm), ed);
  endtask

  task automatic expect_to(input string tag, input int unsigned es, input int unsigned ed);
    bit v, t;
    wait_result(5000, v, t);
    check({tag, "_to"}, 32'(t), 1);
    check({tag, "_novalid"}, 32'(v), 0);
    check({tag, "_sel"}, 32'(sel), es);
    check({tag, "_dist"}, 32'(dist_cm), ed);
  endtask

  task automatic wait_trig(input int unsigned ch, input logic lvl, input int unsigned budget);
    for (int unsigned i = 0; i < budget; i++) begin
      @(negedge clk);
      if (trigger[ch] == lvl) break;
    end
  endtask

  task automatic check_pulses(input string tag, input int unsigned base, input int unsigned exp_ch[5]);
    check({tag, "_npulse"}, pch_q.size() - base, 5);
    for (int unsigned i = 0; i < 5; i++) begin
      check({tag, "_pch"}, pch_q[base + i], exp_ch[i]);
      check({tag, "_pw"}, pw_q[base + i], 10 * P);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end expected end");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned base, nv, nt, nb;
    reset_p = 1'b1; enable = 1'b0; sensor_mask = '0; echo_force = '0;
    big_en = 1'b0; big_mask = 2'b01; big_echo = '0;
    for (int i = 0; i < 4; i++) echo_len[i] = 580;
    repeat (3) @(negedge clk);
    check("rst_trig", 32'(trigger), 0);
    check("rst_sel", 32'(sel), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_dist", 32'(dist_cm), 0);
    check("rst_valid", 32'(dist_valid), 0);
    check("rst_to", 32'(timeout), 0);
    reset_p = 1'b0;

    // Full rotation, 580 us echo -> 10 cm on each channel
    base = pch_q.size();
    sensor_mask = 4'b1111; enable = 1'b1;
    for (int unsigned k = 0; k < 5; k++) expect_dist("rot", k % 4, 10);
    check_pulses("rot", base, '{0, 1, 2, 3, 0});

    // Sparse mask, then mask shrinks while ch3 is mid-shot
    base = pch_q.size();
    sensor_mask = 4'b1010;
    expect_dist("m1010_a", 1, 10);
    expect_dist("m1010_b", 3, 10);
    expect_dist("m1010_c", 1, 10);
    wait_trig(3, 1'b1, 200);
    sensor_mask = 4'b0001;
    expect_dist("midshot", 3, 10);
    expect_dist("after_mid", 0, 10);
    check_pulses("sparse", base, '{1, 3, 1, 3, 0});

    // No echo -> timeout in WAIT_RISE, distance held
    echo_len[2] = 0; sensor_mask = 4'b0100;
    expect_to("noecho", 2, 10);

    // Division boundaries and timeout in MEASURE
    echo_len[0] = 57; sensor_mask = 4'b0001;
    expect_dist("e57", 0, 0);
    echo_len[0] = 58;
    expect_dist("e58", 0, 1);
    echo_len[0] = 1500;
    expect_to("longecho", 0, 1);
    enable = 1'b0;
    for (int unsigned i = 0; i < 4000 && resp_busy; i++) @(negedge clk);

    // Echo stuck high before the trigger is not a rise
    for (int i = 0; i < 4; i++) echo_len[i] = 0;
    echo_force[1] = 1'b1; sensor_mask = 4'b0010; enable = 1'b1;
    expect_to("stuck", 1, 1);
    echo_force[1] = 1'b0;

    // Glitches on unselected channels must not disturb a ch0 shot
    echo_len[0] = 580; sensor_mask = 4'b0001;
    wait_trig(0, 1'b1, 200);
    wait_trig(0, 1'b0, 200);
    repeat (2) @(negedge clk);
    echo_force[2] = 1'b1; repeat (4) @(negedge clk); echo_force[2] = 1'b0;
    repeat (100) @(negedge clk);
    echo_force[3] = 1'b1; repeat (6) @(negedge clk); echo_force[3] = 1'b0;
    expect_dist("glitch", 0, 10);

    // enable drop during MEASURE
    for (int unsigned i = 0; i < 300 && echo_resp[0] == 1'b0; i++) @(negedge clk);
    repeat (50) @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    check("abort_trig", 32'(trigger), 0);
    check("abort_busy", 32'(busy), 0);
    check("abort_sel", 32'(sel), 0);
    nv = n_valid; nt = n_to; nb = n_busy;
    repeat (1400) @(negedge clk);
    check("abort_nvalid", n_valid, nv);
    check("abort_nto", n_to, nt);
    check("abort_idle", n_busy, nb);

    // Asynchronous reset during TRIG
    echo_len[0] = 0; sensor_mask = 4'b1000; enable = 1'b1;
    wait_trig(3, 1'b1, 200);
    check("pre_rst_sel", 32'(sel), 3);
    #1 reset_p = 1'b1;
    #1;
    check("arst_trig", 32'(trigger), 0);
    check("arst_busy", 32'(busy), 0);
    check("arst_sel", 32'(sel), 0);
    check("arst_dist", 32'(dist_cm), 0);
    enable = 1'b0;
    @(negedge clk);
    reset_p = 1'b0;
    nv = n_valid; nt = n_to;
    repeat (100) @(negedge clk);
    check("arst_nvalid", n_valid, nv);
    check("arst_nto", n_to, nt);

    // First pick after reset is the lowest set bit, then circular
    for (int i = 0; i < 4; i++) echo_len[i] = 580;
    sensor_mask = 4'b1001; enable = 1'b1;
    expect_dist("first_pick", 0, 10);
    expect_dist("next_pick", 3, 10);

    // Empty mask never starts a shot
    sensor_mask = '0;
    for (int unsigned i = 0; i < 200 && busy; i++) @(negedge clk);
    nb = n_busy;
    repeat (200) @(negedge clk);
    check("mask0_busy", n_busy, nb);
    check("mask0_trig", 32'(trigger), 0);
    enable = 1'b0;

    // 1 us/clk instances: 29000 us -> 500 cm (div 58) and 580 -> 511 cm (div 50)
    big_en = 1'b1;
    for (int unsigned i = 0; i < 50 && big_trig[0] == 1'b0; i++) @(negedge clk);
    for (int unsigned i = 0; i < 50 && big_trig[0] == 1'b1; i++) @(negedge clk);
    repeat (5) @(negedge clk);
    big_echo[0] = 1'b1;
    repeat (29000) @(negedge clk);
    big_echo[0] = 1'b0;
    for (int unsigned i = 0; i < 100 && !big_dv; i++) @(negedge clk);
    check("big_valid", 32'(big_dv), 1);
    check("big_dist", 32'(big_dist), 500);
    check("big_to", 32'(big_to), 0);
    check("big_sel", 32'(big_sel), 0);
    check("big_busy", 32'(big_busy), 1);
    check("big_trig", 32'(big_trig), 0);
    check("clamp_valid", 32'(clamp_dv), 1);
    check("clamp_dist", 32'(clamp_dist), 511);
    check("clamp_to", 32'(clamp_to), 0);
    check("clamp_sel", 32'(clamp_sel), 0);
    check("clamp_busy", 32'(clamp_busy), 1);
    check("clamp_trig", 32'(clamp_trig), 0);
    big_en = 1'b0;

    check("excl_pulses", n_both, 0);
    check("trig_onehot", n_multi, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ultrasonic_scheduler.md
Name: ultrasonic_scheduler

Overview:
Round-robin measurement scheduler for up to NUM_SENS HC-SR04-style ultrasonic rangers sharing one timing/measurement engine. It selects one enabled sensor at a time, fires its 10 us trigger, times its echo in microseconds, converts the time to centimetres and reports the result tagged with the sensor index. A guard gap between shots suppresses acoustic crosstalk. It sits between the sensor pins and the display/consumer logic.

Parameters:
NUM_SENS, 4, number of sensor channels (2..8)
CLK_PER_US, 100, clk cycles per microsecond tick (100 MHz clk)
TRIG_US, 10, trigger pulse width in us
TIMEOUT_US, 23200, max us in WAIT_RISE or MEASURE before abort
GAP_US, 60000, idle guard time in us after each shot
CM_DIV, 58, us-per-cm divisor

Ports:
clk  in  1  system clock, all logic on posedge
reset_p  in  1  asynchronous active-high reset
enable  in  1  level; 0 aborts and holds IDLE
sensor_mask  in  NUM_SENS  1 = channel participates in rotation
echo  in  NUM_SENS  raw asynchronous echo pins
trigger  out  NUM_SENS  trigger pins, one-hot or zero
sel  out  $clog2(NUM_SENS)  index of channel currently/last serviced
busy  out  1  high in any state except IDLE
dist_cm  out  9  last valid distance, held between updates
dist_valid  out  1  one-cycle pulse, new dist_cm for channel sel
timeout  out  1  one-cycle pulse, shot on channel sel aborted

Behaviour:
- Reset (async): state IDLE, trigger=0, sel=0, busy=0, dist_cm=0, dist_valid=0, timeout=0, prescaler and us counter 0, synchronizers 0.
- Only echo[sel] is used: 2-FF synchronizer, then registered edge detect (rise/fall pulses). Other echo bits ignored.
- us tick: prescaler counts 0..CLK_PER_US-1, one-cycle tick at wrap; prescaler and us counter clear on every state entry.
- States:
  - IDLE: if enable && |sensor_mask -> choose next channel: first set mask bit strictly after sel in circular order (sel itself last); out of reset pick lowest set bit. Load sel, go TRIG. Else stay.
  - TRIG: trigger[sel]=1 for exactly TRIG_US*CLK_PER_US clocks, then 0 -> WAIT_RISE.
  - WAIT_RISE: rise -> MEASURE (us count cleared). us count reaches TIMEOUT_US -> timeout pulse -> GAP. Echo already high on entry (stuck) is not a rise; ends in timeout.
  - MEASURE: fall -> dist_cm = min(floor(us_count/CM_DIV), 511), dist_valid pulse next clock, -> GAP. us count reaches TIMEOUT_US -> timeout pulse, dist_cm unchanged -> GAP.
  - GAP: wait GAP_US, then IDLE.
- Division may be combinational or iterative; dist_valid must assert no later than 40 clocks after fall detect and before GAP exits; dist_cm updates same cycle as dist_valid.
- dist_valid and timeout never both high; each at most once per shot.
- enable=0 in any state: next clock trigger=0, state IDLE, no dist_valid/timeout for the aborted shot; sel keeps value.
- sensor_mask changes take effect at the next IDLE selection only; a running shot completes on its channel even if its bit clears.
- Single set mask bit: same channel repeats every shot.
- Counters wide enough for max(TIMEOUT_US, GAP_US); no wrap-around.

Test Plan:
1. CLK_PER_US=2, GAP_US=20, mask=4'b1111, enable=1, each channel echoes 580 us high 5 us after trigger falls -> trigger pulses 20 clk wide on ch0,1,2,3,0 in order; dist_valid with dist_cm=10 and sel=0,1,2,3.
2. mask=4'b1010 -> only ch1,ch3 alternate; triggers on ch0/ch2 stay 0; mask->4'b0001 mid-shot on ch3 -> ch3 shot completes, next shot ch0.
3. No echo on ch2 -> after TIMEOUT_US in WAIT_RISE, timeout pulse with sel=2, no dist_valid, dist_cm keeps previous 10.
4. Echo high 30000 us -> timeout in MEASURE at 23200 us; echo 29000 us with TIMEOUT_US=40000 -> dist_cm=500; echo 57 us -> dist_cm=0.
5. Deassert enable during MEASURE, and separately assert reset_p during TRIG -> trigger drops, IDLE, no pulses; reset also clears sel, dist_cm to 0.
6. Echo glitch on non-selected channel and echo stuck high before trigger -> ignored / timeout respectively; mask=0 -> busy stays 0.
